add_acc_8bit: RTL and testbench

- Sequential signed add-accumulate unit for the reconfigurable MAC datapath; the addition counterpart of the team's 8-bit subtractor.
- Sums a stream of signed 8-bit operands into a wider accumulator.
- Streams use a valid/ready handshake; a stream is terminated by in_last.
- Presents the sum, an overflow flag and an operand count on a held output channel.

---
 rtl/add_acc_8bit.sv | 141 ++++++++++++++
 tb/tb_add_acc_8bit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_acc_8bit.sv
// add_acc_8bit: sequential signed add-accumulate unit.
// Sums a stream of signed WIDTH-bit operands into an ACC_WIDTH-bit
// accumulator and presents the result on a held output channel.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand present
//   in_ready   block accepts an operand this cycle (registered)
//   in_data    signed operand
//   in_last    final operand of the current stream
//   clear      synchronous abort/flush, overrides everything but reset
//   out_valid  result held
//   out_ready  consumer takes the result
//   out_data   signed sum (saturated or wrapped)
//   out_ovf    overflow occurred somewhere in the stream
//   out_count  operands accepted in the stream, saturating at 255
//
// State  | meaning
// IDLE   | waiting for the first operand of a stream, accumulator is zero
// ACCUM  | stream in progress, accumulating accepted operands
// HOLD   | result presented on out_*, waiting for out_ready
module add_acc_8bit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic [7:0]           out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [7:0]           count;
  logic                 ovf;

  logic                 in_fire;
  logic [ACC_WIDTH:0]   sum;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [7:0]           count_next;
  logic                 ovf_next;

  assign in_fire = in_valid & in_ready;

  // One guard bit above the accumulator: the true sum always fits, so
  // overflow is simply a disagreement between the two top bits.
  assign sum     = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH+1-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

  always_comb begin
    acc_next = sum[ACC_WIDTH-1:0];
    if (SATURATE && sum_ovf) begin
      // The guard bit carries the sign of the true sum.
      acc_next = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  assign ovf_next   = ovf | sum_ovf;
  assign count_next = (count == 8'hFF) ? 8'hFF : count + 8'd1;

  // acc/count/ovf are zeroed as soon as the last operand is captured, so
  // they are already clean when the block returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= acc_next;
              out_ovf   <= ovf_next;
              out_count <= count_next;
              acc       <= '0;
              count     <= '0;
              ovf       <= 1'b0;
            end else begin
              state <= ACCUM;
              acc   <= acc_next;
              count <= count_next;
              ovf   <= ovf_next;
            end
          end
        end
        HOLD: begin
          // in_ready stays low in the handshake cycle; it rises with IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_acc_8bit.sv
module tb_add_acc_8bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [7:0]  out_count;

  // Narrow-accumulator pair (ACC_WIDTH=8), saturating and wrapping.
  logic        v2, l2, r2, clr2;
  logic [7:0]  d2;
  logic        rdy_s, rdy_w, ov_s, ov_w, of_s, of_w;
  logic [7:0]  od_s, od_w, oc_s, oc_w;

  add_acc_8bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_count(out_count)
  );

  add_acc_8bit #(.WIDTH(8), .ACC_WIDTH(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy_s),
    .in_data(d2), .in_last(l2), .clear(clr2),
    .out_valid(ov_s), .out_ready(r2), .out_data(od_s),
    .out_ovf(of_s), .out_count(oc_s)
  );

  add_acc_8bit #(.WIDTH(8), .ACC_WIDTH(8), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy_w),
    .in_data(d2), .in_last(l2), .clear(clr2),
    .out_valid(ov_w), .out_ready(r2), .out_data(od_w),
    .out_ovf(of_w), .out_count(oc_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the default (16-bit, saturating) instance.
  int   m_acc = 0;
  logic m_ovf = 1'b0;
  int   m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int k;
    int s;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (in_ready !== 1'b1) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    s = m_acc + int'($signed(d));
    if (s > 32767) begin
      s = 32767;
      m_ovf = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      m_ovf = 1'b1;
    end
    m_acc = s;
    m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    if (last) begin
      exp_q.push_back('{data: m_acc[15:0], ovf: m_ovf, cnt: m_cnt[7:0]});
      model_reset();
    end
    #1;
    if (last) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    end
  endtask

  task automatic wait_out();
    int   k;
    exp_t e;
    k = 0;
    while (out_valid !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (out_valid !== 1'b1) begin
      chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("unexpected_result", {31'd0, out_valid}, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("out_data",  {16'd0, out_data}, {16'd0, e.data});
    chk("out_ovf",   {31'd0, out_ovf},  {31'd0, e.ovf});
    chk("out_count", {24'd0, out_count}, {24'd0, e.cnt});
    out_ready = 1'b1;
    chk("hold_exit_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
    chk("after_out_valid", {31'd0, out_valid}, 32'd0);
    chk("after_in_ready",  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    int len;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; clear = 1'b0; out_ready = 1'b0;
    v2 = 1'b0; d2 = '0; l2 = 1'b0; r2 = 1'b0; clr2 = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data},  32'd0);
    chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    chk("rst_out_count", {24'd0, out_count}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    #10 rst_n = 1'b1;
    chk("release_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    chk("first_cycle_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic sum: 5 - 3 + 100
    send(8'd5, 1'b0);
    send(8'hFD, 1'b0);
    send(8'd100, 1'b1);
    wait_out();

    // Backpressure: single -7 held for 5 cycles
    send(8'hF9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data",  {16'd0, out_data},  32'h0000FFF9);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      tick();
    end
    wait_out();

    // clear mid-stream, operand 30 discarded
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    in_valid = 1'b1; in_data = 8'd30; in_last = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clear_in_ready",  {31'd0, in_ready},  32'd1);
    send(8'd4, 1'b1);
    wait_out();

    // Negative clamp: 300 x -128, count saturates
    for (int i = 0; i < 300; i++) send(8'h80, (i == 299));
    wait_out();

    // Random streams
    for (int s = 0; s < 4; s++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) send(8'($urandom_range(0, 255)), (i == len - 1));
      wait_out();
    end

    // clear in HOLD with out_ready=1 drops the result
    send(8'd9, 1'b1);
    clear = 1'b1; out_ready = 1'b1;
    void'(exp_q.pop_front());
    tick();
    clear = 1'b0; out_ready = 1'b0;
    chk("clear_hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clear_hold_in_ready",  {31'd0, in_ready},  32'd1);

    // Narrow accumulator: 127 + 127
    chk("narrow_ready", {31'd0, rdy_s & rdy_w}, 32'd1);
    v2 = 1'b1; d2 = 8'd127; l2 = 1'b0;
    tick();
    l2 = 1'b1;
    tick();
    v2 = 1'b0; l2 = 1'b0;
    chk("sat_valid", {31'd0, ov_s}, 32'd1);
    chk("sat_data",  {24'd0, od_s}, 32'h7F);
    chk("sat_ovf",   {31'd0, of_s}, 32'd1);
    chk("sat_count", {24'd0, oc_s}, 32'd2);
    chk("wrap_valid", {31'd0, ov_w}, 32'd1);
    chk("wrap_data",  {24'd0, od_w}, 32'hFE);
    chk("wrap_ovf",   {31'd0, of_w}, 32'd1);
    r2 = 1'b1;
    tick();
    r2 = 1'b0;
    chk("narrow_released", {31'd0, ov_s | ov_w}, 32'd0);

    // Async reset in HOLD
    send(8'd3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data",  {16'd0, out_data},  32'd0);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
    exp_q.delete();
    model_reset();
    #2 rst_n = 1'b1;
    tick();
    chk("arst_release_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    wait_out();

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
